// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential PC generation, valid/ready requests to instruction memory,
// and an in-order queue of returned instructions with redirect flush and stale-response dropping.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [63:0]              imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  input  logic                     stall,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [63:0]              out_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef logic [AW:0] ptr_t;

  logic [63:0] pc;
  ptr_t        head_ptr, fill_ptr, tail_ptr, drop_cnt;
  logic [63:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  ptr_t        pending, redirect_drop;
  logic [AW+1:0] budget, drop_sum;
  logic        req_hs, rsp_fill, rsp_drop, pop;

  // head..fill are filled entries, fill..tail are pending; in-order fill keeps this contiguous
  assign level     = tail_ptr - head_ptr;
  assign pending   = tail_ptr - fill_ptr;
  assign budget    = {1'b0, level} + {1'b0, drop_cnt};
  assign drop_sum  = {1'b0, drop_cnt} + {1'b0, pending};

  assign imem_req_valid = arst_n & ~redirect_valid & (budget < DEPTH_W);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & (pending != '0) & ~redirect_valid;

  assign out_valid = (head_ptr != fill_ptr);
  assign pop       = out_valid & ~stall & ~redirect_valid;
  assign out_inst  = out_valid ? inst_mem[head_ptr[AW-1:0]] : '0;
  assign out_pc    = out_valid ? pc_mem[head_ptr[AW-1:0]]   : '0;

  // A response arriving with the redirect is one of the dropped ones, so it is not counted twice
  assign redirect_drop = ptr_t'((imem_rsp_valid && (drop_sum != '0)) ? drop_sum - 1'b1 : drop_sum);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc       <= RESET_PC;
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      drop_cnt <= redirect_drop;
    end else begin
      if (req_hs) begin
        pc       <= pc + PC_STEP;
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (rsp_fill) fill_ptr <= fill_ptr + 1'b1;
      if (pop)      head_ptr <= head_ptr + 1'b1;
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs)   pc_mem[tail_ptr[AW-1:0]]   <= pc;
    if (rsp_fill) inst_mem[fill_ptr[AW-1:0]] <= imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (arst_n)
      assert (!(imem_rsp_valid && (drop_cnt == '0) && (pending == '0)))
        else $error("unexpected imem response with nothing outstanding");
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: memory responder model plus a scoreboard of expected
// queue entries, checked every cycle and at the key points of each scenario.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [2:0]  level;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0), .PC_STEP(64'd4)) dut (
    .clk(clk), .arst_n(arst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] inst; bit filled; } exp_t;
  typedef struct { logic [63:0] addr; int due; bit stale; } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  int          errors = 0, checks = 0, cyc = 0, lat = 1;
  bit          rsp_en = 1'b1;
  logic [63:0] pc_m = 64'h0;
  logic        snap_rv, snap_ov;
  logic [63:0] snap_addr, snap_pc;
  logic [31:0] snap_inst;
  logic [2:0]  snap_level;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive responder, check all outputs against the model, advance model at the edge
  task automatic cycle();
    bit   exp_rv, exp_ov, hs, rsp, st, found;
    mem_t m;
    imem_rsp_valid = rsp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? inst_of(mem_q[0].addr) : 32'h0;
    #1;
    exp_rv = !redirect_valid && ((exp_q.size() + stale_cnt()) < DEPTH);
    exp_ov = (exp_q.size() > 0) && exp_q[0].filled;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, pc_m);
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("out_pc", out_pc, exp_ov ? exp_q[0].pc : 64'h0);
    chk("out_inst", 64'(out_inst), exp_ov ? 64'(exp_q[0].inst) : 64'h0);
    snap_rv = imem_req_valid; snap_addr = imem_req_addr; snap_ov = out_valid;
    snap_pc = out_pc; snap_inst = out_inst; snap_level = level;
    hs  = exp_rv && imem_req_ready;
    rsp = imem_rsp_valid;
    st  = 1'b0;
    @(posedge clk);
    if (rsp) begin
      m  = mem_q.pop_front();
      st = m.stale;
    end
    if (redirect_valid) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      pc_m = redirect_pc;
    end else begin
      if (exp_ov && !stall) void'(exp_q.pop_front());
      if (rsp && !st) begin
        found = 1'b0;
        foreach (exp_q[i]) if (!found && !exp_q[i].filled) begin
          exp_q[i].filled = 1'b1;
          found = 1'b1;
        end
      end
      if (hs) begin
        exp_q.push_back('{pc: pc_m, inst: inst_of(pc_m), filled: 1'b0});
        mem_q.push_back('{addr: pc_m, due: cyc + lat, stale: 1'b0});
        pc_m = pc_m + 64'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    arst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; stall = 1'b0;
    #2;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_inst", 64'(out_inst), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    exp_q.delete(); mem_q.delete(); pc_m = 64'h0; cyc = 0;
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    int n;
    #1;
    // 1: streaming with 1-cycle latency
    reset_dut();
    lat = 1; rsp_en = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 0) chk("t1_first_addr", snap_addr, 64'h0);
      if (i >= 2) begin
        chk("t1_out_valid", 64'(snap_ov), 64'h1);
        chk("t1_out_pc", snap_pc, 64'(4 * (i - 2)));
      end
    end

    // 2: responses withheld, issue caps at DEPTH
    reset_dut();
    rsp_en = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_full_req_valid", 64'(snap_rv), 64'h0);
    chk("t2_full_level", 64'(snap_level), 64'd4);
    rsp_en = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!snap_rv && n < 10);
    chk("t2_resume_seen", 64'(snap_rv), 64'h1);
    chk("t2_resume_addr", snap_addr, 64'd16);
    for (int i = 0; i < 6; i++) cycle();

    // 3: stall holding head pc=8
    reset_dut();
    imem_req_ready = 1'b1;
    n = 0;
    while (!(exp_q.size() > 0 && exp_q[0].filled && exp_q[0].pc == 64'd8) && n < 10) begin
      cycle(); n++;
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_valid", 64'(snap_ov), 64'h1);
      chk("t3_hold_pc", snap_pc, 64'd8);
      chk("t3_hold_inst", 64'(snap_inst), 64'(inst_of(64'd8)));
    end
    stall = 1'b0;
    cycle();
    chk("t3_release_pc", snap_pc, 64'd8);
    cycle();
    chk("t3_next_pc", snap_pc, 64'd12);
    for (int i = 0; i < 10; i++) cycle();

    // 4: redirect with two requests in flight
    reset_dut();
    lat = 3; imem_req_ready = 1'b1;
    cycle(); cycle();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h100;
    cycle();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!snap_ov && n < 15);
    chk("t4_first_valid", 64'(snap_ov), 64'h1);
    chk("t4_first_pc", snap_pc, 64'h100);
    chk("t4_first_inst", 64'(snap_inst), 64'(inst_of(64'h100)));
    for (int i = 0; i < 8; i++) cycle();

    // 5: redirect together with a response and a pop
    reset_dut();
    lat = 2; imem_req_ready = 1'b1;
    n = 0;
    while (!(exp_q.size() > 0 && exp_q[0].filled && mem_q.size() >= 2 &&
             mem_q[0].due <= cyc) && n < 12) begin
      cycle(); n++;
    end
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    cycle();
    chk("t5_redirect_out_valid", 64'(snap_ov), 64'h1);
    redirect_valid = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!snap_ov && n < 15);
    chk("t5_first_valid", 64'(snap_ov), 64'h1);
    chk("t5_first_pc", snap_pc, 64'h200);
    for (int i = 0; i < 8; i++) cycle();

    // 6: asynchronous reset mid-stream with three entries allocated
    reset_dut();
    lat = 1; rsp_en = 1'b0; imem_req_ready = 1'b1;
    cycle(); cycle(); cycle();
    imem_req_ready = 1'b0;
    cycle();
    chk("t6_level_before", 64'(snap_level), 64'd3);
    reset_dut();
    rsp_en = 1'b1; imem_req_ready = 1'b1;
    cycle();
    chk("t6_restart_valid", 64'(snap_rv), 64'h1);
    chk("t6_restart_addr", snap_addr, 64'h0);
    for (int i = 0; i < 6; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
